gearbox_align_ctrl: RTL and testbench
=====================================

Name: gearbox_align_ctrl

Overview:
- Word-alignment training controller for the 6-to-12 sensor gearbox.
- Sweeps the gearbox bit-slip offset (0..11) while the sensor sends a fixed training word, and locks on the first offset that gives a stable match.
- Monitors the locked offset and raises loss-of-lock on sustained mismatch.
- Sits in the px_clk domain between the sensor control/register block and the gearbox slip_num input.

Parameters:
- TRAIN_WORD, 12'hF00, expected 12-bit training word at gearbox output.
- SETTLE_CYCLES, 8, px_clk cycles to wait after every slip change before comparing (covers the gearbox pipeline and clkdiv6 crossing); legal range 1..255.
- MATCH_CYCLES, 16, consecutive matching words required to declare lock; legal range 1..255.
- LOSS_THRESH, 4, consecutive mismatching words in LOCKED that declare loss of lock; legal range 1..15.

Ports:
- px_clk  in  1  pixel clock; all logic on its rising edge.
- px_reset_n  in  1  synchronous, active-low reset.
- train_start  in  1  one-cycle pulse; starts or restarts training.
- train_en  in  1  level; while high, LOCKED monitoring is active; low freezes monitoring only.
- din  in  12  gearbox output word.
- slip_num  out  4  slip offset driven to the gearbox, 0..11 only.
- busy  out  1  high in SETTLE or CHECK.
- locked  out  1  high in LOCKED.
- train_fail  out  1  sticky; set when all 12 offsets fail, cleared by train_start or reset.
- lock_lost  out  1  one-cycle pulse on a LOCKED-to-SETTLE loss transition.

Behaviour:
- Reset (px_reset_n low at a clock edge): state IDLE, slip_num=0, busy=0, locked=0, train_fail=0, lock_lost=0, all counters 0. Reset mid-training aborts immediately.
- All outputs are registered.
- States:
  - IDLE: outputs static. train_start -> SETTLE with slip_num=0, settle_cnt=0, train_fail cleared.
  - SETTLE: settle_cnt increments each cycle. When settle_cnt==SETTLE_CYCLES-1 -> CHECK with match_cnt=0.
  - CHECK: if din==TRAIN_WORD, match_cnt increments; when match_cnt reaches MATCH_CYCLES-1 on a matching word -> LOCKED. Any mismatch -> NEXT.
  - NEXT (one cycle): if slip_num==11 -> FAIL with slip_num=0. Otherwise slip_num+1 -> SETTLE with settle_cnt=0.
  - LOCKED: locked=1, slip_num held.
    - While train_en=1: each mismatch increments loss_cnt; each match clears it.
    - loss_cnt reaching LOSS_THRESH -> lock_lost pulse, slip_num=0, -> SETTLE (automatic retrain).
    - train_en=0: loss_cnt cleared and held at 0.
  - FAIL: train_fail=1, slip_num=0. train_start -> SETTLE.
- train_start in any state other than IDLE or FAIL restarts the sweep: slip_num=0, counters cleared, -> SETTLE, locked drops on the next cycle. This also applies when train_start coincides with a loss event: restart wins, no lock_lost pulse.
- Latencies:
  - Minimum time from train_start to locked=1 (offset 0 good): 1 + SETTLE_CYCLES + MATCH_CYCLES cycles.
  - Each failed offset costs SETTLE_CYCLES + (cycles spent in CHECK) + 1.
- Width rules:
  - Counters are 8 bits; loss_cnt is 4 bits.
  - slip_num never exceeds 11, and there is no wrap to 12..15.
- Comparison is exact on all 12 bits; no masking.

Test Plan:
- Pattern correct at offset 0, SETTLE=8, MATCH=16: pulse train_start -> locked=1 exactly 25 cycles later, slip_num=0, train_fail=0.
- Gearbox model produces TRAIN_WORD only at slip 7 -> slip_num steps 0..7, each step dwells at least SETTLE_CYCLES, locked=1 with slip_num=7, busy=0.
- TRAIN_WORD never produced -> after offset 11 fails: train_fail=1, slip_num=0, locked=0. A second train_start clears train_fail and restarts at 0.
- In LOCKED with train_en=1, inject 3 mismatches, 1 match, then 4 mismatches -> no loss on the first burst; lock_lost single pulse after the 4th consecutive mismatch; state SETTLE with slip_num=0.
- Same mismatch burst with train_en=0 -> locked stays 1, no lock_lost.
- Deassert px_reset_n during CHECK at slip 5 -> next cycle all outputs at reset values. Assert train_start mid-sweep at slip 3 -> slip_num=0 on the next cycle.

Source files
------------

// File: rtl/gearbox_align_ctrl.sv
// gearbox_align_ctrl
// Word-alignment training controller for the 6-to-12 sensor gearbox.
// Sweeps the gearbox bit-slip offset 0..11 while the sensor sends a fixed
// training word, locks on the first offset that gives a stable match, then
// watches the locked offset and retrains automatically on sustained mismatch.
// All outputs come straight from flops and track the state register.
module gearbox_align_ctrl #(
  parameter logic [11:0] TRAIN_WORD    = 12'hF00,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MATCH_CYCLES  = 16,
  parameter int unsigned LOSS_THRESH   = 4
) (
  input  logic        px_clk,
  input  logic        px_reset_n,
  input  logic        train_start,
  input  logic        train_en,
  input  logic [11:0] din,
  output logic [3:0]  slip_num,
  output logic        busy,
  output logic        locked,
  output logic        train_fail,
  output logic        lock_lost
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CYCLES - 1);
  localparam logic [3:0] LOSS_LAST   = 4'(LOSS_THRESH - 1);
  localparam logic [3:0] SLIP_LAST   = 4'd11;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCheck,
    StNext,
    StLocked,
    StFail
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] slip_q, slip_d;
  logic [7:0] settleCnt_q, settleCnt_d;
  logic [7:0] matchCnt_q, matchCnt_d;
  logic [3:0] lossCnt_q, lossCnt_d;
  logic       busy_q, busy_d;
  logic       locked_q, locked_d;
  logic       trainFail_q, trainFail_d;
  logic       lockLost_q, lockLost_d;
  logic       lossEvent;
  logic       wordMatch;

  assign wordMatch = (din == TRAIN_WORD);

  // State register and registered outputs; reset aborts any training in flight.
  always_ff @(posedge px_clk) begin
    if (!px_reset_n) begin
      state_q     <= StIdle;
      slip_q      <= 4'd0;
      settleCnt_q <= 8'd0;
      matchCnt_q  <= 8'd0;
      lossCnt_q   <= 4'd0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      trainFail_q <= 1'b0;
      lockLost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slip_q      <= slip_d;
      settleCnt_q <= settleCnt_d;
      matchCnt_q  <= matchCnt_d;
      lossCnt_q   <= lossCnt_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      trainFail_q <= trainFail_d;
      lockLost_q  <= lockLost_d;
    end
  end

  // Next-state logic; a train_start pulse restarts the sweep from any state and beats a loss event.
  always_comb begin
    state_d     = state_q;
    slip_d      = slip_q;
    settleCnt_d = settleCnt_q;
    matchCnt_d  = matchCnt_q;
    lossCnt_d   = lossCnt_q;
    lossEvent   = 1'b0;

    if (train_start) begin
      state_d     = StSettle;
      slip_d      = 4'd0;
      settleCnt_d = 8'd0;
      matchCnt_d  = 8'd0;
      lossCnt_d   = 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StIdle;
        end

        StSettle: begin
          if (settleCnt_q == SETTLE_LAST) begin
            state_d     = StCheck;
            settleCnt_d = 8'd0;
            matchCnt_d  = 8'd0;
          end else begin
            settleCnt_d = settleCnt_q + 8'd1;
          end
        end

        StCheck: begin
          if (wordMatch) begin
            if (matchCnt_q == MATCH_LAST) begin
              state_d    = StLocked;
              matchCnt_d = 8'd0;
              lossCnt_d  = 4'd0;
            end else begin
              matchCnt_d = matchCnt_q + 8'd1;
            end
          end else begin
            state_d    = StNext;
            matchCnt_d = 8'd0;
          end
        end

        StNext: begin
          if (slip_q == SLIP_LAST) begin
            state_d = StFail;
            slip_d  = 4'd0;
          end else begin
            state_d     = StSettle;
            slip_d      = slip_q + 4'd1;
            settleCnt_d = 8'd0;
          end
        end

        StLocked: begin
          if (!train_en || wordMatch) begin
            lossCnt_d = 4'd0;
          end else if (lossCnt_q == LOSS_LAST) begin
            lossEvent   = 1'b1;
            state_d     = StSettle;
            slip_d      = 4'd0;
            settleCnt_d = 8'd0;
            matchCnt_d  = 8'd0;
            lossCnt_d   = 4'd0;
          end else begin
            lossCnt_d = lossCnt_q + 4'd1;
          end
        end

        StFail: begin
          slip_d = 4'd0;
        end

        default: begin
          state_d = StIdle;
          slip_d  = 4'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every flag lines up with the state register.
  always_comb begin
    busy_d      = (state_d == StSettle) || (state_d == StCheck);
    locked_d    = (state_d == StLocked);
    trainFail_d = (state_d == StFail);
    lockLost_d  = lossEvent;
  end

  assign slip_num   = slip_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign train_fail = trainFail_q;
  assign lock_lost  = lockLost_q;

endmodule

// File: tb/tb_gearbox_align_ctrl.sv
// tb_gearbox_align_ctrl
// Directed bench for the gearbox alignment controller. Stimulus pushes
// expected output snapshots, stamped with the cycle they are due, into a
// queue; an independent monitor pops and compares them on the falling edge.
module tb_gearbox_align_ctrl;

  localparam logic [11:0] TRAIN_WORD = 12'hF00;

  logic        px_clk;
  logic        px_reset_n;
  logic        train_start;
  logic        train_en;
  logic [11:0] din;
  logic [3:0]  slip_num;
  logic        busy;
  logic        locked;
  logic        train_fail;
  logic        lock_lost;

  int   cycleCnt = 0;
  int   goodSlip = 0;
  logic injectBad = 1'b0;
  int   nCompared = 0;
  int   nMismatched = 0;

  typedef struct {
    int         due;
    string      name;
    logic [3:0] slip;
    logic       busy;
    logic       locked;
    logic       fail;
    logic       lost;
  } exp_t;

  exp_t expQ[$];

  gearbox_align_ctrl #(
    .TRAIN_WORD   (TRAIN_WORD),
    .SETTLE_CYCLES(8),
    .MATCH_CYCLES (16),
    .LOSS_THRESH  (4)
  ) dut (
    .px_clk     (px_clk),
    .px_reset_n (px_reset_n),
    .train_start(train_start),
    .train_en   (train_en),
    .din        (din),
    .slip_num   (slip_num),
    .busy       (busy),
    .locked     (locked),
    .train_fail (train_fail),
    .lock_lost  (lock_lost)
  );

  // Gearbox model: the training word only appears at the good slip; near-miss words elsewhere.
  assign din = injectBad ? 12'h700 :
               ((int'(slip_num) == goodSlip) ? TRAIN_WORD : 12'hF01);

  // Free-running clock.
  initial begin
    px_clk = 1'b0;
    forever #5 px_clk = ~px_clk;
  end

  // Cycle stamp used to schedule expectations.
  always @(posedge px_clk) cycleCnt <= cycleCnt + 1;

  // Compare one expected snapshot against the live outputs.
  task automatic checkOutput(input exp_t e);
    nCompared++;
    if (e.due != cycleCnt || slip_num !== e.slip || busy !== e.busy ||
        locked !== e.locked || train_fail !== e.fail || lock_lost !== e.lost) begin
      nMismatched++;
      $display("[TB] FAIL %s @cycle %0d (due %0d): got slip=%0d busy=%b locked=%b fail=%b lost=%b, want slip=%0d busy=%b locked=%b fail=%b lost=%b",
               e.name, cycleCnt, e.due, slip_num, busy, locked, train_fail, lock_lost,
               e.slip, e.busy, e.locked, e.fail, e.lost);
    end
  endtask

  // Monitor: pops every expectation that has come due and checks it.
  always @(negedge px_clk) begin
    while (expQ.size() > 0 && expQ[0].due <= cycleCnt) begin
      checkOutput(expQ.pop_front());
    end
  end

  task automatic pushExpect(input int due, input string name, input logic [3:0] slip,
                            input logic b, input logic l, input logic f, input logic x);
    exp_t e;
    e.due = due; e.name = name; e.slip = slip;
    e.busy = b; e.locked = l; e.fail = f; e.lost = x;
    expQ.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge px_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic en, input logic bad);
    train_start = start;
    train_en    = en;
    injectBad   = bad;
  endtask

  // Pulses train_start for one cycle; returns the cycle of the edge that sampled it.
  task automatic startTraining(output int s);
    applyStimulus(1'b1, train_en, injectBad);
    tick(1);
    train_start = 1'b0;
    s = cycleCnt;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int c;
    px_reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    goodSlip = 0;
    tick(3);
    pushExpect(cycleCnt, "reset", 4'd0, 0, 0, 0, 0);
    tick(1);
    px_reset_n = 1'b1;
    tick(2);
    pushExpect(cycleCnt, "idle", 4'd0, 0, 0, 0, 0);
    tick(1);

    // Offset 0 good: lock 25 cycles after train_start goes high.
    startTraining(s);
    pushExpect(s,      "t1_settle",  4'd0, 1, 0, 0, 0);
    pushExpect(s + 23, "t1_prelock", 4'd0, 1, 0, 0, 0);
    pushExpect(s + 24, "t1_lock",    4'd0, 0, 1, 0, 0);
    tick(26);

    // Training word only at slip 7: ten cycles per failed offset.
    goodSlip = 7;
    startTraining(s);
    for (int k = 0; k < 8; k++) begin
      pushExpect(s + 10*k,     $sformatf("t2_enter%0d", k), 4'(k), 1, 0, 0, 0);
      pushExpect(s + 10*k + 7, $sformatf("t2_dwell%0d", k), 4'(k), 1, 0, 0, 0);
      if (k < 7) pushExpect(s + 10*k + 9, $sformatf("t2_next%0d", k), 4'(k), 0, 0, 0, 0);
    end
    pushExpect(s + 93, "t2_prelock", 4'd7, 1, 0, 0, 0);
    pushExpect(s + 94, "t2_lock",    4'd7, 0, 1, 0, 0);
    tick(94);

    // Mismatch burst with monitoring frozen: lock must hold.
    c = cycleCnt;
    for (int i = 1; i <= 6; i++) pushExpect(c + i, $sformatf("t5_hold%0d", i), 4'd7, 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(6);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // 3 bad, 1 good, 4 bad with monitoring on: loss only after the 4th consecutive bad word.
    c = cycleCnt;
    for (int i = 1; i <= 7; i++) pushExpect(c + i, $sformatf("t4_hold%0d", i), 4'd7, 0, 1, 0, 0);
    pushExpect(c + 8,   "t4_lost",     4'd0, 1, 0, 0, 1);
    pushExpect(c + 9,   "t4_pulseend", 4'd0, 1, 0, 0, 0);
    pushExpect(c + 101, "t4_prelock",  4'd7, 1, 0, 0, 0);
    pushExpect(c + 102, "t4_relock",   4'd7, 0, 1, 0, 0);
    injectBad = 1'b1;
    tick(3);
    injectBad = 1'b0;
    tick(1);
    injectBad = 1'b1;
    tick(4);
    injectBad = 1'b0;
    tick(94);

    // Restart mid-sweep at slip 3, then reset during CHECK at slip 5.
    startTraining(s);
    pushExpect(s,      "t6_restart_from_lock", 4'd0, 1, 0, 0, 0);
    pushExpect(s + 32, "t6_slip3",             4'd3, 1, 0, 0, 0);
    pushExpect(s + 33, "t6_restart_slip0",     4'd0, 1, 0, 0, 0);
    pushExpect(s + 33 + 58, "t6_check5",       4'd5, 1, 0, 0, 0);
    pushExpect(s + 33 + 59, "t6_reset",        4'd0, 0, 0, 0, 0);
    pushExpect(s + 33 + 62, "t6_idle_after",   4'd0, 0, 0, 0, 0);
    tick(32);
    train_start = 1'b1;
    tick(1);
    train_start = 1'b0;
    tick(58);
    px_reset_n = 1'b0;
    tick(2);
    px_reset_n = 1'b1;
    tick(3);

    // No offset works: fail after slip 11, then a second start clears it.
    goodSlip = -1;
    startTraining(s);
    pushExpect(s,       "t3_start",   4'd0,  1, 0, 0, 0);
    pushExpect(s + 110, "t3_slip11",  4'd11, 1, 0, 0, 0);
    pushExpect(s + 119, "t3_next11",  4'd11, 0, 0, 0, 0);
    pushExpect(s + 120, "t3_fail",    4'd0,  0, 0, 1, 0);
    pushExpect(s + 125, "t3_sticky",  4'd0,  0, 0, 1, 0);
    tick(125);
    goodSlip = 0;
    startTraining(s);
    pushExpect(s,      "t3_clear", 4'd0, 1, 0, 0, 0);
    pushExpect(s + 24, "t3_lock",  4'd0, 0, 1, 0, 0);
    tick(26);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) tick(1);
    if (expQ.size() > 0) begin
      nMismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
